// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: owns the PC, issues single-cycle imem requests,
// buffers {instr, pc} in a small FIFO and hands them to decode over valid/ready.
module fetch_unit #(
  parameter int unsigned            XLEN     = 32,
  parameter logic [XLEN-1:0]        RESET_PC = '0,
  parameter int unsigned            DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [31:0]     imem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            id_ready_i,
  output logic            id_valid_o,
  output logic [31:0]     id_instr_o,
  output logic [XLEN-1:0] id_pc_o,
  output logic [XLEN-1:0] id_pc4_o
);

  localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned CW1 = CW + 1;
  localparam logic [CW:0] DEPTH_C = CW1'(DEPTH);

  logic [XLEN-1:0] pc_q;
  logic            inflight_q;
  logic [XLEN-1:0] inflight_pc_q;
  logic [CW-1:0]   count_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW-1:0]   wr_ptr_q;
  logic [31:0]     instr_mem_q [DEPTH];
  logic [XLEN-1:0] pc_mem_q    [DEPTH];

  logic            pop;
  logic            push;
  logic [CW:0]     occ;

  assign id_valid_o  = (count_q != '0);
  assign id_instr_o  = instr_mem_q[rd_ptr_q];
  assign id_pc_o     = pc_mem_q[rd_ptr_q];
  assign id_pc4_o    = id_pc_o + XLEN'(4);
  assign imem_addr_o = pc_q;

  assign pop  = id_valid_o & id_ready_i;
  assign push = inflight_q & ~redirect_i;
  assign occ  = {1'b0, count_q} + CW1'(inflight_q);

  // occ - pop < DEPTH, rearranged to avoid underflow; reset gates the request
  // because the occupancy term alone would already allow issue.
  assign imem_req_o = reset & ~redirect_i & (occ < (DEPTH_C + CW1'(pop)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else if (redirect_i) begin
      pc_q       <= {redirect_pc_i[XLEN-1:2], 2'b00};
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      inflight_q <= imem_req_o;
      if (imem_req_o) begin
        pc_q          <= pc_q + XLEN'(4);
        inflight_pc_q <= pc_q;
      end
      if (push) begin
        instr_mem_q[wr_ptr_q] <= imem_rdata_i;
        pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
        wr_ptr_q              <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic, checked
// each cycle against a queue-based model of the fetch/deliver stream.
module tb_fetch_unit;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        id_ready_i;
  logic        id_valid_o;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_pc4_o;

  fetch_unit #(
    .XLEN    (32),
    .RESET_PC(32'h0000_0000),
    .DEPTH   (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_rdata_i (imem_rdata_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .id_ready_i   (id_ready_i),
    .id_valid_o   (id_valid_o),
    .id_instr_o   (id_instr_o),
    .id_pc_o      (id_pc_o),
    .id_pc4_o     (id_pc4_o)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Instruction memory contents: a distinct word per address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0000_0013;
  endfunction

  // Reference model: program counter, one in-flight fetch, queue of fetched PCs.
  logic [31:0] m_pc;
  bit          m_inf;
  logic [31:0] m_inf_pc;
  logic [31:0] m_q[$];
  logic [31:0] m_next;

  bit          o_req, o_valid;
  logic [31:0] o_addr, o_pc, o_pc4;

  task automatic model_reset();
    m_pc     = 32'h0;
    m_inf    = 1'b0;
    m_inf_pc = 32'h0;
    m_q.delete();
    m_next   = 32'h0;
  endtask

  task automatic step(input bit rdr, input logic [31:0] rpc, input bit rdy);
    bit pop, e_req;
    redirect_i    = rdr;
    redirect_pc_i = rpc;
    id_ready_i    = rdy;
    #1;
    pop   = (m_q.size() != 0) && rdy;
    e_req = !rdr && ((int'(m_q.size()) + int'(m_inf) - int'(pop)) < int'(DEPTH));
    chk("req", imem_req_o, e_req);
    chk("addr", imem_addr_o, m_pc);
    chk("valid", id_valid_o, m_q.size() != 0);
    if (m_q.size() != 0) begin
      chk("pc", id_pc_o, m_q[0]);
      chk("pc4", id_pc4_o, m_q[0] + 32'd4);
      chk("instr", id_instr_o, mem_word(m_q[0]));
      chk("order", id_pc_o, m_next);
    end
    o_req   = imem_req_o;
    o_valid = id_valid_o;
    o_addr  = imem_addr_o;
    o_pc    = id_pc_o;
    o_pc4   = id_pc4_o;
    if (pop) m_next = m_q[0] + 32'd4;
    if (rdr) begin
      m_q.delete();
      m_inf  = 1'b0;
      m_pc   = {rpc[31:2], 2'b00};
      m_next = m_pc;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (m_inf) m_q.push_back(m_inf_pc);
      m_inf = e_req;
      if (e_req) begin
        m_inf_pc = m_pc;
        m_pc     = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    imem_rdata_i = o_req ? mem_word(o_addr) : $urandom;
  endtask

  task automatic async_reset();
    #3;
    reset = 1'b0;
    #1;
    chk("rst_req", imem_req_o, 1'b0);
    chk("rst_valid", id_valid_o, 1'b0);
    chk("rst_addr", imem_addr_o, 32'h0);
    chk("rst_pc", id_pc_o, 32'h0);
    chk("rst_pc4", id_pc4_o, 32'h4);
    chk("rst_instr", id_instr_o, 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic redirect_seq(input string tag, input logic [31:0] rpc);
    logic [31:0] tgt;
    tgt = {rpc[31:2], 2'b00};
    step(1'b1, rpc, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    chk({tag, "_r1_valid"}, o_valid, 1'b0);
    chk({tag, "_r1_req"}, o_req, 1'b1);
    chk({tag, "_r1_addr"}, o_addr, tgt);
    step(1'b0, 32'h0, 1'b1);
    chk({tag, "_r2_valid"}, o_valid, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    chk({tag, "_r3_valid"}, o_valid, 1'b1);
    chk({tag, "_r3_pc"}, o_pc, tgt);
  endtask

  initial begin
    reset         = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    id_ready_i    = 1'b1;
    imem_rdata_i  = 32'h0;
    model_reset();
    #2;
    chk("init_req", imem_req_o, 1'b0);
    chk("init_addr", imem_addr_o, 32'h0);
    chk("init_valid", id_valid_o, 1'b0);
    chk("init_pc", id_pc_o, 32'h0);
    chk("init_pc4", id_pc4_o, 32'h4);
    chk("init_instr", id_instr_o, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Fill and full-rate streaming.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 32'h0, 1'b1);
      chk("fill_addr", o_addr, 32'(i) * 32'd4);
      chk("fill_valid", o_valid, i >= 2);
      if (i >= 2) chk("fill_pc", o_pc, 32'(i - 2) * 32'd4);
    end

    // Mid-stream reset, then backpressure right after the first valid.
    async_reset();
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 32'h0, 1'b0);
      chk("bp_valid", o_valid, 1'b1);
      chk("bp_hold", o_pc, 32'h0);
    end
    chk("bp_req_low", o_req, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 1'b1);
      chk("bp_valid_rel", o_valid, 1'b1);
      chk("bp_release", o_pc, 32'(i) * 32'd4);
    end

    redirect_seq("redir100", 32'h0000_0100);
    redirect_seq("redir203", 32'h0000_0203);
    step(1'b0, 32'h0, 1'b1);
    chk("redir203_next", o_pc, 32'h204);

    redirect_seq("wrap", 32'hFFFF_FFFC);
    chk("wrap_pc4", o_pc4, 32'h0);
    step(1'b0, 32'h0, 1'b1);
    chk("wrap_next", o_pc, 32'h0);

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 3) != 0);
      if ((i % 700) == 699) async_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
